adder_chain_arbiter: RTL and testbench
======================================

# adder_chain_arbiter

- Shares one W-bit ripple-carry adder datapath between two requesters.
- Each requester sends a packet of one or more beats that form a multi-word addition, least-significant word first.
- The arbiter grants the adder round-robin per packet and locks the grant until the packet's last beat.
- It chains the carry between beats internally and returns each word's sum through a one-entry registered output with valid/ready backpressure.

## Interface
Parameters:
- W, default 8: operand/sum width per beat; the adder is W-bit, carry-in/carry-out 1 bit.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 beat valid.
- req0_ready  out  1  requester 0 beat accepted this cycle when high with req0_valid.
- req0_a, req0_b  in  W  requester 0 operand words.
- req0_cin  in  1  requester 0 carry-in; used on the first beat of a packet only.
- req0_last  in  1  marks requester 0's final beat of the packet.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin, req1_last: same as above, for requester 1.
- res_valid  out  1  result register holds a word.
- res_ready  in  1  consumer takes the result when high with res_valid.
- res_sum  out  W  sum word.
- res_cout  out  1  carry-out of that word.
- res_id  out  1  requester that issued the beat.
- res_last  out  1  copy of the beat's last flag.

## Operation
- States:
  - IDLE: no packet in progress.
  - LOCK: packet in progress for requester `owner`.
- Grant in IDLE:
  - Among asserted valids; if both are asserted, choose requester `rr_ptr`.
  - rr_ptr resets to 0.
  - When a packet completes (last beat accepted), rr_ptr = 1 − id of that packet.
  - A single valid requester is granted regardless of rr_ptr.
- Grant in LOCK: owner only; the other requester's ready stays 0.
- `slot_free` = !res_valid || res_ready.
- reqX_ready = grant_X && slot_free. Ready depends combinationally on the valids, res_ready and state, never on reqX data.
- Beat accept (valid && ready):
  - Carry in is the requester's cin when in IDLE (first beat), else carry_reg.
  - sum/cout = a + b + cin at full W+1 width; the low W bits go to sum, bit W goes to cout.
  - Result register loads {sum, cout, id, last}; res_valid is set.
  - carry_reg ← cout.
  - If last: go to IDLE, clear carry_reg, update rr_ptr.
  - Otherwise: go to LOCK with owner = id.
- A single-beat packet (last on the first beat) never enters LOCK.
- Owner drops valid mid-packet: remain in LOCK, carry_reg held, no beats accepted, other requester stays blocked.
- Requesters must hold valid, a, b, cin and last stable until accepted. This is not checked.
- res_valid clears when res_ready is high and no new beat is accepted that cycle. A simultaneous drain and accept keeps res_valid high with the new word.
- Arithmetic wraps modulo 2^W per word; overflow is reported only through res_cout.

## Timing
- Reset values: res_valid=0, res_sum=0, res_cout=0, res_id=0, res_last=0, req0_ready=0, req1_ready=0; state=IDLE, rr_ptr=0, carry_reg=0.
- Reset asserted mid-packet aborts the packet; the partial carry and any pending result are discarded.
- Latency: beat accepted at edge N → result visible on res_* after edge N, valid during cycle N+1.
- Throughput: one beat per cycle while res_ready=1; with res_ready=0 and res_valid=1, both readies are 0.
- Packet switch: the last beat of one packet and the first beat of the next packet (either requester) may be accepted on consecutive cycles, with no bubble.
- res_* outputs are registered only; no combinational path from req* inputs to res*.

## Test plan
- Single beat: W=8, req0 a=0xB5 b=0xA7 cin=0 last=1 → next cycle res_sum=0x5C res_cout=1 res_id=0 res_last=1; req0_ready high the cycle of accept.
- Carry chain: req1 beats (0xFF,0x01,cin=1,last=0), (0x00,0x00,last=1) → results 0x01/cout1, then 0x01/cout0 res_last=1. Beat 2 uses the internal carry; req1_cin is ignored on beat 2.
- Round-robin: both valid every cycle with single-beat packets from reset → ids alternate 0,1,0,1; with only req1 valid, req1 granted each cycle.
- Lock: req0 3-beat packet, req1 valid throughout → req1_ready=0 until req0 last accepted; req1 granted on the next cycle; the req0 gap (valid low one cycle mid-packet) does not release the lock.
- Backpressure: res_ready=0 for 4 cycles with a result pending → both readies 0, res_* stable; res_ready=1 → drain and accept in the same cycle, no lost or duplicated word.
- Reset mid-packet: rst_n low asynchronously during LOCK → all outputs 0 immediately. After release, a req1 single beat is granted first with cin taken from req1_cin (carry_reg=0).

Source files
------------

// File: rtl/adder_chain_arbiter_if.sv
// Bundle of the two requester beat channels, the result channel and FSM debug taps
// for adder_chain_arbiter. The arbiter connects through the slave modport.
interface adder_chain_arbiter_if #(
  parameter int W = 8
);
  // Handshake rule for every channel: a beat or word transfers on a rising clock
  // edge where valid and ready are both high; the sender holds its payload stable
  // while valid is high and ready is low.
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;
  logic         req0_last;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;
  logic         req1_last;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_id;
  logic         res_last;

  logic         dbg_state;
  logic         dbg_owner;
  logic         dbg_rr_ptr;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin, req0_last,
    input  req1_valid, req1_a, req1_b, req1_cin, req1_last,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_id, res_last,
    output dbg_state, dbg_owner, dbg_rr_ptr
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin, req0_last,
    output req1_valid, req1_a, req1_b, req1_cin, req1_last,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_id, res_last,
    input  dbg_state, dbg_owner, dbg_rr_ptr
  );
endinterface

// File: rtl/adder_chain_arbiter.sv
// Two requesters share one W-bit adder; multi-beat packets chain their carry and
// the grant is held per packet, round-robin between packets.
module adder_chain_arbiter #(
  parameter int W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  adder_chain_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t       state;
  logic         owner;
  logic         rr_ptr;
  logic         carry_reg;

  logic         res_valid_q;
  logic [W-1:0] res_sum_q;
  logic         res_cout_q;
  logic         res_id_q;
  logic         res_last_q;

  logic         slot_free;
  logic         grant0;
  logic         grant1;
  logic         ready0;
  logic         ready1;
  logic         accept0;
  logic         accept1;
  logic         accept;
  logic         sel_id;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_last;
  logic         cin_eff;
  logic [W:0]   full_sum;

  // Readies look only at valids, the result slot and the FSM, never at payload.
  // They are forced low while reset is held so the bus is quiet during reset.
  always_comb begin
    slot_free = !res_valid_q || bus.res_ready;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !rr_ptr);
        grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_ptr);
      end
      LOCK: begin
        grant0 = !owner;
        grant1 =  owner;
      end
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
    ready0  = grant0 && slot_free && rst_n;
    ready1  = grant1 && slot_free && rst_n;
    accept0 = bus.req0_valid && ready0;
    accept1 = bus.req1_valid && ready1;
    accept  = accept0 || accept1;
    sel_id  = accept1;
  end

  // First beat of a packet takes the requester's carry-in, later beats the chain.
  always_comb begin
    op_a     = sel_id ? bus.req1_a    : bus.req0_a;
    op_b     = sel_id ? bus.req1_b    : bus.req0_b;
    op_last  = sel_id ? bus.req1_last : bus.req0_last;
    cin_eff  = (state == IDLE) ? (sel_id ? bus.req1_cin : bus.req0_cin) : carry_reg;
    full_sum = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin_eff};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      rr_ptr      <= 1'b0;
      carry_reg   <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= 1'b0;
      res_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        res_valid_q <= 1'b1;
        res_sum_q   <= full_sum[W-1:0];
        res_cout_q  <= full_sum[W];
        res_id_q    <= sel_id;
        res_last_q  <= op_last;
        if (op_last) begin
          state     <= IDLE;
          carry_reg <= 1'b0;
          rr_ptr    <= !sel_id;
        end else begin
          state     <= LOCK;
          owner     <= sel_id;
          carry_reg <= full_sum[W];
        end
      end else if (bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_sum    = res_sum_q;
  assign bus.res_cout   = res_cout_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_last   = res_last_q;
  assign bus.dbg_state  = state;
  assign bus.dbg_owner  = owner;
  assign bus.dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_adder_chain_arbiter.sv
// Directed and random stimulus for adder_chain_arbiter with a reference model of
// arbitration, carry chaining and the result slot feeding an expected-word queue.
module tb_adder_chain_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_chain_arbiter_if #(.W(W)) bus ();

  adder_chain_arbiter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W+2:0] exp_q[$];

  logic m_rv, m_lock, m_owner, m_rr, m_carry;
  logic acc0_seen, acc1_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rv = 1'b0; m_lock = 1'b0; m_owner = 1'b0; m_rr = 1'b0; m_carry = 1'b0;
    acc0_seen = 1'b0; acc1_seen = 1'b0;
    exp_q.delete();
  endtask

  task automatic set0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic last);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
    bus.req0_cin = cin; bus.req0_last = last;
  endtask

  task automatic set1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic last);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
    bus.req1_cin = cin; bus.req1_last = last;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_res_valid"},  32'(bus.res_valid),  32'(0));
    check({tag, "_res_sum"},    32'(bus.res_sum),    32'(0));
    check({tag, "_res_cout"},   32'(bus.res_cout),   32'(0));
    check({tag, "_res_id"},     32'(bus.res_id),     32'(0));
    check({tag, "_res_last"},   32'(bus.res_last),   32'(0));
    check({tag, "_req0_ready"}, 32'(bus.req0_ready), 32'(0));
    check({tag, "_req1_ready"}, 32'(bus.req1_ready), 32'(0));
  endtask

  // One clock of checking: compare readies/state/result against the model at the
  // falling edge, then advance the model with whatever the rising edge will do.
  task automatic tick();
    logic g0, g1, sf, r0, r1, a0, a1, id, cin, last;
    logic [W-1:0] a, b;
    logic [W:0]   full;
    @(negedge clk);
    sf = !m_rv || bus.res_ready;
    if (m_lock) begin
      g0 = !m_owner;
      g1 = m_owner;
    end else begin
      g0 = bus.req0_valid && (!bus.req1_valid || !m_rr);
      g1 = bus.req1_valid && (!bus.req0_valid ||  m_rr);
    end
    r0 = g0 && sf;
    r1 = g1 && sf;
    check("req0_ready", 32'(bus.req0_ready), 32'(r0));
    check("req1_ready", 32'(bus.req1_ready), 32'(r1));
    check("res_valid",  32'(bus.res_valid),  32'(m_rv));
    check("dbg_state",  32'(bus.dbg_state),  32'(m_lock));
    if (m_rv) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL res_word observed=%0h expected=none", {bus.res_sum, bus.res_cout, bus.res_id, bus.res_last});
      end else begin
        check("res_word", 32'({bus.res_sum, bus.res_cout, bus.res_id, bus.res_last}), 32'(exp_q[0]));
        if (bus.res_ready) void'(exp_q.pop_front());
      end
    end
    a0 = bus.req0_valid && r0;
    a1 = bus.req1_valid && r1 && !a0;
    if (a0 || a1) begin
      id   = a1;
      a    = a1 ? bus.req1_a    : bus.req0_a;
      b    = a1 ? bus.req1_b    : bus.req0_b;
      last = a1 ? bus.req1_last : bus.req0_last;
      cin  = m_lock ? m_carry : (a1 ? bus.req1_cin : bus.req0_cin);
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      exp_q.push_back({full[W-1:0], full[W], id, last});
      m_rv = 1'b1;
      if (last) begin
        m_lock = 1'b0; m_carry = 1'b0; m_rr = !id;
      end else begin
        m_lock = 1'b1; m_owner = id; m_carry = full[W];
      end
    end else if (bus.res_ready) begin
      m_rv = 1'b0;
    end
    acc0_seen = a0;
    acc1_seen = a1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set0(1'b0, '0, '0, 1'b0, 1'b0);
    set1(1'b0, '0, '0, 1'b0, 1'b0);
    bus.res_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("por");
    check("por_rr_ptr", 32'(bus.dbg_rr_ptr), 32'(0));
    rst_n = 1'b1;
    tick();

    // Single beat from requester 0
    set0(1'b1, 8'hB5, 8'hA7, 1'b0, 1'b1);
    tick();
    set0(1'b0, '0, '0, 1'b0, 1'b0);
    check("single_sum",  32'(bus.res_sum),  32'h5C);
    check("single_cout", 32'(bus.res_cout), 32'(1));
    check("single_id",   32'(bus.res_id),   32'(0));
    check("single_last", 32'(bus.res_last), 32'(1));
    tick();

    // Two-beat carry chain from requester 1; second cin must be ignored
    set1(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0);
    tick();
    check("chain1_sum",  32'(bus.res_sum),  32'h01);
    check("chain1_cout", 32'(bus.res_cout), 32'(1));
    check("chain_owner", 32'(bus.dbg_owner), 32'(1));
    set1(1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
    tick();
    check("chain2_sum",  32'(bus.res_sum),  32'h01);
    check("chain2_cout", 32'(bus.res_cout), 32'(0));
    check("chain2_last", 32'(bus.res_last), 32'(1));
    check("chain2_id",   32'(bus.res_id),   32'(1));
    set1(1'b0, '0, '0, 1'b0, 1'b0);
    tick();

    // Round-robin with both requesters always valid
    set0(1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
    set1(1'b1, 8'h30, 8'h40, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_id", 32'(bus.res_id), 32'(k % 2));
    end
    set0(1'b0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("solo1_id", 32'(bus.res_id), 32'(1));
    end
    set1(1'b0, '0, '0, 1'b0, 1'b0);
    tick();

    // Lock: requester 0 three-beat packet with a gap, requester 1 waiting
    set0(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    set1(1'b1, 8'h05, 8'h06, 1'b0, 1'b1);
    set0(1'b1, 8'hF0, 8'h44, 1'b1, 1'b0);
    tick();
    set0(1'b0, '0, '0, 1'b0, 1'b0);
    check("lock_gap_block", 32'(bus.req1_ready), 32'(0));
    tick();
    set0(1'b1, 8'hF0, 8'h0F, 1'b0, 1'b1);
    check("lock_last_block", 32'(bus.req1_ready), 32'(0));
    tick();
    set0(1'b0, '0, '0, 1'b0, 1'b0);
    check("lock_release", 32'(bus.req1_ready), 32'(1));
    tick();
    set1(1'b0, '0, '0, 1'b0, 1'b0);

    // Backpressure with a word pending and requesters waiting
    set0(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1);
    set1(1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
    bus.res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp_ready0", 32'(bus.req0_ready), 32'(0));
      check("bp_ready1", 32'(bus.req1_ready), 32'(0));
    end
    bus.res_ready = 1'b1;
    tick();
    set0(1'b0, '0, '0, 1'b0, 1'b0);
    set1(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) tick();

    // Random traffic; payload only changes once accepted or while not valid
    for (int k = 0; k < 400; k++) begin
      if (!bus.req0_valid || acc0_seen)
        set0(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
      if (!bus.req1_valid || acc1_seen)
        set1(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
      bus.res_ready = $urandom_range(0, 3) != 0;
      tick();
    end

    // Drain, then reset in the middle of a packet
    set0(1'b0, '0, '0, 1'b0, 1'b0);
    set1(1'b0, '0, '0, 1'b0, 1'b0);
    bus.res_ready = 1'b1;
    repeat (12) tick();
    set0(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    check("pre_reset_lock", 32'(bus.dbg_state), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("mid_reset");
    check("mid_reset_state", 32'(bus.dbg_state), 32'(0));
    model_reset();
    set0(1'b0, '0, '0, 1'b0, 1'b0);
    set1(1'b1, 8'h03, 8'h04, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_sum", 32'(bus.res_sum), 32'h08);
    check("post_reset_id",  32'(bus.res_id),  32'(1));
    set1(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) tick();

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
